// File: rtl/pll_rst_pkg.sv
// Shared types and configuration checks for the PLL reset sequencer.
package pll_rst_pkg;

    typedef enum logic [2:0] {
        StAssertRst,
        StWaitLock,
        StStable,
        StRun,
        StFail
    } seq_state_e;

    localparam int unsigned RetryW = 4;

    // True when every cycle parameter is usable and fits the shared counter.
    function automatic bit cfg_ok(input int unsigned rst_pulse, input int unsigned lock_timeout,
                                  input int unsigned lock_stable, input int unsigned retry_max,
                                  input int unsigned cnt_w);
        longint unsigned cap;
        cap = 64'd1 << cnt_w;
        return (rst_pulse >= 1) && (lock_timeout >= 1) && (lock_stable >= 1) &&
               (retry_max < (32'd1 << RetryW)) && (cnt_w >= 1) && (cnt_w <= 32) &&
               (64'(rst_pulse) <= cap) && (64'(lock_timeout) <= cap) &&
               (64'(lock_stable) <= cap);
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for a single asynchronous status bit, cleared by reset.
module pll_lock_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock acquisition and qualification, then releases system reset.
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned RETRY_MAX           = 7,
    parameter int unsigned CNT_W               = 16
) (
    input  logic              refclk_i,
    input  logic              rst_i,
    input  logic              pll_locked_i,
    output logic              pll_rst_o,
    output logic              sys_rst_o,
    output logic              ready_o,
    output logic              lock_lost_o,
    output logic [RetryW-1:0] retry_cnt_o,
    output logic              fail_o
);

    if (!cfg_ok(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES, RETRY_MAX, CNT_W))
    begin : g_cfg_err
        $error("pll_reset_sequencer: invalid parameter set");
    end

    localparam logic [CNT_W-1:0]  RstLast     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TimeoutLast = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  StableLast  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RetryW-1:0] RetryLimit  = RetryW'(RETRY_MAX);

    seq_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [RetryW-1:0] retry_q;
    logic              pll_rst_q;
    logic              sys_rst_q;
    logic              ready_q;
    logic              lock_lost_q;
    logic              fail_q;
    logic              lk;

    pll_lock_sync u_lock_sync (
        .clk_i (refclk_i),
        .rst_i (rst_i),
        .d_i   (pll_locked_i),
        .q_o   (lk)
    );

    // Outputs are written alongside each transition so they track the state being entered.
    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            state_q     <= StAssertRst;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            lock_lost_q <= 1'b0;
            unique case (state_q)
                StAssertRst: begin
                    if (cnt_q == RstLast) begin
                        state_q   <= StWaitLock;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitLock: begin
                    if (lk) begin
                        state_q <= StStable;
                        cnt_q   <= '0;
                    end else if (cnt_q == TimeoutLast) begin
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        if (retry_q == RetryLimit) begin
                            state_q <= StFail;
                            fail_q  <= 1'b1;
                        end else begin
                            state_q <= StAssertRst;
                            retry_q <= retry_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStable: begin
                    if (!lk) begin
                        state_q <= StWaitLock;
                        cnt_q   <= '0;
                    end else if (cnt_q == StableLast) begin
                        state_q   <= StRun;
                        cnt_q     <= '0;
                        retry_q   <= '0;
                        sys_rst_q <= 1'b0;
                        ready_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    if (!lk) begin
                        state_q     <= StAssertRst;
                        cnt_q       <= '0;
                        pll_rst_q   <= 1'b1;
                        sys_rst_q   <= 1'b1;
                        ready_q     <= 1'b0;
                        lock_lost_q <= 1'b1;
                    end
                end
                StFail: begin
                    fail_q <= 1'b1;
                end
                default: begin
                    state_q   <= StAssertRst;
                    cnt_q     <= '0;
                    pll_rst_q <= 1'b1;
                    sys_rst_q <= 1'b1;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst_o   = pll_rst_q;
    assign sys_rst_o   = sys_rst_q;
    assign ready_o     = ready_q;
    assign lock_lost_o = lock_lost_q;
    assign retry_cnt_o = retry_q;
    assign fail_o      = fail_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: expected event times are derived arithmetically from the
// sequencing rules and compared against a per-cycle trace of the outputs.
module tb_pll_reset_sequencer;

    localparam int RstPulse    = 4;
    localparam int LockTimeout = 20;
    localparam int LockStable  = 8;
    localparam int RetryMax    = 2;
    localparam int Period      = RstPulse + LockTimeout;
    localparam int TrLen       = 16384;

    typedef struct packed {
        logic       pll_rst;
        logic       sys_rst;
        logic       ready;
        logic       lock_lost;
        logic       fail;
        logic [3:0] retry;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pin = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lock_lost;
    logic [3:0] retry_cnt;
    logic       fail;

    obs_t tr [TrLen];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #10 clk = ~clk;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (RstPulse),
        .LOCK_TIMEOUT_CYCLES (LockTimeout),
        .LOCK_STABLE_CYCLES  (LockStable),
        .RETRY_MAX           (RetryMax),
        .CNT_W               (16)
    ) dut (
        .refclk_i     (clk),
        .rst_i        (rst),
        .pll_locked_i (pin),
        .pll_rst_o    (pll_rst),
        .sys_rst_o    (sys_rst),
        .ready_o      (ready),
        .lock_lost_o  (lock_lost),
        .retry_cnt_o  (retry_cnt),
        .fail_o       (fail)
    );

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check(input string tag, input int t, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, t, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= TrLen) begin
            $display("FAIL trace_overflow: cycle %0d reached limit %0d", cyc, TrLen);
            $fatal(1, "trace buffer exhausted");
        end
        tr[cyc] = '{pll_rst: pll_rst, sys_rst: sys_rst, ready: ready, lock_lost: lock_lost,
                    fail: fail, retry: retry_cnt};
    endtask

    task automatic advance_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic reset_dut(output int r);
        rst = 1'b1;
        tick();
        r   = cyc;
        rst = 1'b0;
        check("rst_pll_rst", r, int'(tr[r].pll_rst), 1);
        check("rst_sys_rst", r, int'(tr[r].sys_rst), 1);
        check("rst_ready", r, int'(tr[r].ready), 0);
        check("rst_lock_lost", r, int'(tr[r].lock_lost), 0);
        check("rst_retry", r, int'(tr[r].retry), 0);
        check("rst_fail", r, int'(tr[r].fail), 0);
    endtask

    task automatic chk_pulse(input string tag, input int start);
        for (int i = 0; i < RstPulse; i++) check(tag, start + i, int'(tr[start + i].pll_rst), 1);
        check(tag, start + RstPulse, int'(tr[start + RstPulse].pll_rst), 0);
    endtask

    // n failed lock windows after reset sample r, pin low throughout them.
    task automatic chk_windows(input int r, input int n);
        int f;
        for (int a = 0; a < n; a++) begin
            f = r + RstPulse + a * Period;
            chk_pulse("retry_pulse", f - RstPulse);
            check("window_retry", f, int'(tr[f].retry), a);
            check("window_low_end", f + LockTimeout - 1, int'(tr[f + LockTimeout - 1].pll_rst), 0);
            check("timeout_pll_rst", f + LockTimeout, int'(tr[f + LockTimeout].pll_rst), 1);
        end
    endtask

    // k timeouts, then the pin rises d cycles relative to the next pll_rst fall; optional
    // one-cycle dropout at STABLE count g; lock loss h cycles into RUN, re-raised q later.
    task automatic attempt(input int k, input int d, input bit glitch, input int g,
                           input int h, input int q);
        int r, f, p, e, x, rdy, l, f2, e2, rdy2, last, early;
        pin = 1'b0;
        reset_dut(r);
        f = r + RstPulse + k * Period;
        if (k > RetryMax) begin
            last = f - Period + LockTimeout;
            advance_to(last + 40);
            chk_windows(r, k);
            check("fail_before", last - 1, int'(tr[last - 1].fail), 0);
            check("fail_set", last, int'(tr[last].fail), 1);
            check("fail_retry", last, int'(tr[last].retry), RetryMax);
            check("fail_hold", last + 40, int'(tr[last + 40].fail), 1);
            check("fail_pll_rst", last + 40, int'(tr[last + 40].pll_rst), 1);
            check("fail_sys_rst", last + 40, int'(tr[last + 40].sys_rst), 1);
            check("fail_ready", last + 40, int'(tr[last + 40].ready), 0);
            return;
        end
        p = f + d;
        advance_to(p);
        pin = 1'b1;
        e   = imax(p + 3, f + 1);
        rdy = e + LockStable;
        if (glitch) begin
            x = e + g - 2;
            advance_to(x);
            pin = 1'b0;
            advance_to(x + 1);
            pin = 1'b1;
            rdy = x + 1 + LockStable + 3;
        end
        l = rdy + h;
        advance_to(l);
        pin = 1'b0;
        advance_to(l + q);
        pin  = 1'b1;
        f2   = l + 3 + RstPulse;
        e2   = imax(l + q + 3, f2 + 1);
        rdy2 = e2 + LockStable;
        advance_to(rdy2 + 2);

        chk_windows(r, k);
        chk_pulse("lock_pulse", f - RstPulse);
        early = 0;
        for (int t = r; t < rdy; t++) early += int'(tr[t].ready);
        check("no_early_ready", rdy - 1, early, 0);
        check("retry_pre_run", rdy - 1, int'(tr[rdy - 1].retry), k);
        check("sys_rst_pre_run", rdy - 1, int'(tr[rdy - 1].sys_rst), 1);
        check("ready_rise", rdy, int'(tr[rdy].ready), 1);
        check("sys_rst_release", rdy, int'(tr[rdy].sys_rst), 0);
        check("retry_run", rdy, int'(tr[rdy].retry), 0);
        check("fail_run", rdy, int'(tr[rdy].fail), 0);
        check("run_before_loss", l + 2, int'(tr[l + 2].ready), 1);
        check("no_loss_early", l + 2, int'(tr[l + 2].lock_lost), 0);
        check("lock_lost", l + 3, int'(tr[l + 3].lock_lost), 1);
        check("loss_ready", l + 3, int'(tr[l + 3].ready), 0);
        check("loss_sys_rst", l + 3, int'(tr[l + 3].sys_rst), 1);
        check("lock_lost_one", l + 4, int'(tr[l + 4].lock_lost), 0);
        chk_pulse("loss_pulse", l + 3);
        check("relock_pre", rdy2 - 1, int'(tr[rdy2 - 1].ready), 0);
        check("relock_ready", rdy2, int'(tr[rdy2].ready), 1);
        check("relock_retry", rdy2, int'(tr[rdy2].retry), 0);
    endtask

    task automatic abort_in_wait();
        int r, f;
        pin = 1'b0;
        reset_dut(r);
        f = r + RstPulse + Period;
        advance_to(f + 7);
        check("abort_retry", f + 7, int'(tr[f + 7].retry), 1);
        check("abort_pll_rst", f + 7, int'(tr[f + 7].pll_rst), 0);
    endtask

    initial begin
        int k, d;
        repeat (2) tick();
        attempt(0, 5, 1'b0, 0, 2, 4);     // normal lock, then loss in RUN
        attempt(0, -4, 1'b0, 0, 1, 1);    // lock already present on first WAIT_LOCK cycle
        attempt(0, 5, 1'b1, 5, 3, 6);     // dropout at STABLE count 5
        attempt(1, 17, 1'b0, 0, 1, 2);    // lock lands on the last timeout cycle
        attempt(1, -6, 1'b0, 0, 2, 3);    // lock one cycle too late: timeout, then relock
        attempt(RetryMax + 1, 0, 1'b0, 0, 0, 0);
        attempt(0, 2, 1'b0, 0, 1, 5);     // reset out of the failed state
        abort_in_wait();
        attempt(2, 3, 1'b1, 0, 4, 10);    // reset out of WAIT_LOCK
        for (int it = 0; it < 12; it++) begin
            k = int'($urandom_range(0, RetryMax));
            d = (k == 0) ? int'($urandom_range(0, 21)) - 4 : int'($urandom_range(0, 23)) - 6;
            attempt(k, d, 1'($urandom_range(0, 1)), int'($urandom_range(0, LockStable - 1)),
                    int'($urandom_range(1, 6)), int'($urandom_range(1, 10)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Drives the PLL's reset input and consumes its `locked` output. It sequences PLL reset, lock acquisition, lock qualification and the release of system reset. The block sits between board reset and the Qsys system, clocked from the 50 MHz reference clock. It retries failed locks up to a bounded count, re-sequences on lock loss, and flags permanent failure.

Parameters:
RST_PULSE_CYCLES, 16, cycles `pll_rst` is held high per attempt (>=1)
LOCK_TIMEOUT_CYCLES, 50000, cycles allowed for lock after `pll_rst` falls (1 ms at 50 MHz)
LOCK_STABLE_CYCLES, 1024, consecutive synced-locked cycles required before release
RETRY_MAX, 7, timeouts tolerated before FAIL (retry_cnt width 4, RETRY_MAX<=15)
CNT_W, 16, shared counter width; must hold max of the three cycle parameters minus 1

Ports:
refclk  in  1  sole clock, 50 MHz reference
rst  in  1  synchronous, active-high reset
pll_locked  in  1  PLL lock indication; asynchronous to refclk
pll_rst  out  1  reset to PLL, active high
sys_rst  out  1  system reset, active high, synchronous to refclk
ready  out  1  high while in RUN
lock_lost  out  1  one-cycle pulse on lock loss in RUN
retry_cnt  out  4  timeouts since last RUN entry
fail  out  1  sticky; retry budget exhausted

Behaviour:
- Reset values (rst high at an edge): state ASSERT_RST, cnt=0, pll_rst=1, sys_rst=1, ready=0, lock_lost=0, retry_cnt=0, fail=0, sync flops 0. Applies mid-operation, including from FAIL, at the next edge.
- pll_locked passes through a 2-flop synchronizer to give lk. The FSM uses only lk. All outputs are registered.
- ASSERT_RST: pll_rst=1, sys_rst=1. cnt counts 0..RST_PULSE_CYCLES-1, then the FSM moves to WAIT_LOCK with cnt=0. lk is ignored in this state.
- WAIT_LOCK: pll_rst=0.
  - lk=1 -> STABLE, cnt=0. A lock on the first cycle is accepted.
  - If cnt==LOCK_TIMEOUT_CYCLES-1 and lk=0, a timeout occurs:
    - if retry_cnt==RETRY_MAX -> FAIL;
    - else retry_cnt+1 -> ASSERT_RST.
  - If lk=1 on the timeout cycle, lock wins and there is no retry.
- STABLE: pll_rst=0, sys_rst=1.
  - lk=0 -> WAIT_LOCK with cnt=0 (fresh timeout window, retry_cnt unchanged).
  - cnt==LOCK_STABLE_CYCLES-1 with lk=1 -> RUN.
- RUN: sys_rst=0, ready=1; retry_cnt is cleared on entry.
  - lk=0 -> lock_lost=1 for exactly one cycle, sys_rst=1, ready=0, then ASSERT_RST with cnt=0.
- FAIL: pll_rst=1, sys_rst=1, ready=0, fail=1. The only exit is rst.
- Latency: a pll_locked pin edge reaches lk after 2 edges. Registered outputs change on the 3rd edge. RUN exit therefore occurs 3 edges after the pin falls.
- Release: ready/sys_rst change on the same edge as the RUN entry. This is LOCK_STABLE_CYCLES+3 edges after the pin rises in WAIT_LOCK (1 cycle to enter STABLE + N stable cycles + sync).
- cnt never wraps; it is cleared on every state change. retry_cnt saturates by construction (FAIL at RETRY_MAX).

Decomposition:
- Package pll_rst_pkg:
  - state encoding (ASSERT_RST, WAIT_LOCK, STABLE, RUN, FAIL);
  - retry_cnt width constant 4;
  - elaboration-time parameter range checks.
- Sub-module pll_lock_sync: 2-flop bit synchronizer, reset to 0, reusable for other async status bits.
- FSM, counter and output registers live in the top module.

Test Plan:
Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, RETRY_MAX=2.
1. Normal lock:
   - stimulus: release rst; raise pll_locked 5 cycles after pll_rst falls; hold it.
   - response: pll_rst high exactly 4 cycles; ready=1/sys_rst=0 exactly 11 edges after pin rise; retry_cnt=0, fail=0.
2. Never lock:
   - stimulus: pll_locked=0 throughout.
   - response: 3 pll_rst pulses of 4 cycles separated by 20-cycle low windows; after the 3rd timeout fail=1, retry_cnt=2, pll_rst held 1, sys_rst=1 indefinitely.
3. Stability glitch:
   - stimulus: lock, then drop pll_locked for 1 cycle while STABLE cnt=5, then re-raise.
   - response: no ready; FSM returns through WAIT_LOCK; ready rises 11 edges after the re-rise; retry_cnt=0.
4. Lock loss in RUN:
   - stimulus: drop pll_locked while ready=1.
   - response: 3 edges later lock_lost is high for one cycle, sys_rst=1, ready=0; pll_rst high 4 cycles; raising the lock again recovers to RUN.
5. Timeout edge:
   - stimulus: after one prior timeout (retry_cnt=1), raise the pin so lk=1 exactly at cnt=19.
   - response: enters STABLE, retry_cnt stays 1 and clears to 0 on RUN entry.
6. Reset mid-operation:
   - stimulus: assert rst for 1 cycle in WAIT_LOCK; separately in FAIL.
   - response: next edge all outputs at reset values (fail=0, retry_cnt=0, pll_rst=1); the sequence restarts with a full 4-cycle pll_rst pulse.
